r4_frame_sequencer: RTL and testbench

//  Frame controller for the 4-bit radix-4 butterfly datapath. Collects one frame of four

---
 rtl/r4_frame_sequencer.sv | 178 +++++++++++++++++
 tb/tb_r4_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/r4_frame_sequencer.sv
// r4_frame_sequencer
//   Frame controller for the radix-4 butterfly datapath. It collects four complex
//   samples, holds them on the butterfly inputs, and steps the butterfly control
//   word through the four output indices k=0..3. Each result is captured and
//   offered on an output stream that supports backpressure.
//
//   Handshake rule, both streams: a transfer happens on a rising CLK edge where
//   valid and ready are both high. A source holds valid and data stable until
//   that edge. s_ready and m_valid depend only on the registered state, so
//   neither has a combinational path from the inputs.
//
// Ports
//   CLK, RST             clock (rising edge), asynchronous active-low reset
//   abort                synchronous discard of the partial or in-flight frame
//   s_valid/s_ready      input sample stream; s_re/s_im are the sample parts
//   bf_xr/bf_xi          held sample parts {x3,x2,x1,x0}, slot n at [n*W +: W]
//   bf_c1/bf_c2/bf_c3    registered butterfly control word
//   bf_xro/bf_xio        butterfly result for the current control word
//   m_valid/m_ready      result stream; m_re/m_im are the result, m_idx is k
//   busy                 low only when idle (LOAD with no sample buffered)
//   frame_cnt            completed frames, wraps 255 -> 0
//   dbg_state            current FSM state (LOAD=0, ISSUE=1, WAIT=2, OUT=3)
module r4_frame_sequencer #(
    parameter int         W   = 4,
    parameter int         LAT = 2,
    parameter logic [2:0] CW0 = 3'b011,
    parameter logic [2:0] CW1 = 3'b110,
    parameter logic [2:0] CW2 = 3'b000,
    parameter logic [2:0] CW3 = 3'b101
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           abort,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_re,
    input  logic [W-1:0]   s_im,
    output logic [4*W-1:0] bf_xr,
    output logic [4*W-1:0] bf_xi,
    output logic           bf_c1,
    output logic           bf_c2,
    output logic           bf_c3,
    input  logic [W-1:0]   bf_xro,
    input  logic [W-1:0]   bf_xio,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_re,
    output logic [W-1:0]   m_im,
    output logic [1:0]     m_idx,
    output logic           busy,
    output logic [7:0]     frame_cnt,
    output logic [1:0]     dbg_state
);

    localparam int CNT_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ld_cnt;
    logic [1:0]       k;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       cw_sel;
    logic             wait_last;
    logic             m_fire;

    assign wait_last = (wait_cnt == CNT_W'(1));
    assign m_fire    = (state == ST_OUT) && m_ready;

    always_comb begin
        cw_sel = CW0;
        case (k)
            2'd0:    cw_sel = CW0;
            2'd1:    cw_sel = CW1;
            2'd2:    cw_sel = CW2;
            default: cw_sel = CW3;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (s_valid && ld_cnt == 2'd3) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (wait_last) state_nxt = ST_OUT;
            ST_OUT:   if (m_ready) state_nxt = (k == 2'd3) ? ST_LOAD : ST_ISSUE;
            default:  state_nxt = ST_LOAD;
        endcase
        if (abort) state_nxt = ST_LOAD;
    end

    // Outputs decoded from the registered state
    always_comb begin
        s_ready   = (state == ST_LOAD);
        m_valid   = (state == ST_OUT);
        busy      = !((state == ST_LOAD) && (ld_cnt == 2'd0));
        dbg_state = state;
    end

    // Datapath and counters
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ld_cnt    <= 2'd0;
            k         <= 2'd0;
            wait_cnt  <= '0;
            bf_xr     <= '0;
            bf_xi     <= '0;
            bf_c1     <= 1'b0;
            bf_c2     <= 1'b0;
            bf_c3     <= 1'b0;
            m_re      <= '0;
            m_im      <= '0;
            m_idx     <= 2'd0;
            frame_cnt <= 8'd0;
        end else if (abort) begin
            // Sample buffer, captured result and frame count are kept as they are;
            // a beat accepted in this cycle is not written.
            ld_cnt <= 2'd0;
            k      <= 2'd0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (s_valid) begin
                        for (int n = 0; n < 4; n++) begin
                            if (ld_cnt == 2'(n)) begin
                                bf_xr[n*W +: W] <= s_re;
                                bf_xi[n*W +: W] <= s_im;
                            end
                        end
                        ld_cnt <= ld_cnt + 2'd1;
                        if (ld_cnt == 2'd3) k <= 2'd0;
                    end
                end
                ST_ISSUE: begin
                    {bf_c1, bf_c2, bf_c3} <= cw_sel;
                    wait_cnt              <= CNT_W'(LAT);
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    // Butterfly output has settled by the last wait cycle
                    if (wait_last) begin
                        m_re  <= bf_xro;
                        m_im  <= bf_xio;
                        m_idx <= k;
                    end
                end
                ST_OUT: begin
                    if (m_fire) begin
                        if (k == 2'd3) begin
                            frame_cnt <= frame_cnt + 8'd1;
                            k         <= 2'd0;
                        end else begin
                            k <= k + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_r4_frame_sequencer.sv
// Directed bench for r4_frame_sequencer with a small butterfly model in the loop.
module tb_r4_frame_sequencer;

    localparam int W = 4;
    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic           CLK = 1'b0;
    logic           RST;
    logic           abort;
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_re;
    logic [W-1:0]   s_im;
    logic [4*W-1:0] bf_xr;
    logic [4*W-1:0] bf_xi;
    logic           bf_c1, bf_c2, bf_c3;
    logic [W-1:0]   bf_xro = '0;
    logic [W-1:0]   bf_xio = '0;
    logic           m_valid;
    logic           m_ready;
    logic [W-1:0]   m_re;
    logic [W-1:0]   m_im;
    logic [1:0]     m_idx;
    logic           busy;
    logic [7:0]     frame_cnt;
    logic [1:0]     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_frames = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_im_q[$];

    r4_frame_sequencer dut (
        .CLK(CLK), .RST(RST), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .bf_xr(bf_xr), .bf_xi(bf_xi),
        .bf_c1(bf_c1), .bf_c2(bf_c2), .bf_c3(bf_c3),
        .bf_xro(bf_xro), .bf_xio(bf_xio),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im), .m_idx(m_idx),
        .busy(busy), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Butterfly model: xro = {0,c1,c2,c3}, xio = x0 real. Result appears two cycles
    // after the control word is chosen in ISSUE (registered control bits + this stage).
    always @(posedge CLK) begin
        bf_xro <= {1'b0, bf_c1, bf_c2, bf_c3};
        bf_xio <= bf_xr[W-1:0];
    end

    function automatic logic [2:0] cw_of(input int k);
        case (k)
            0:       return 3'b011;
            1:       return 3'b110;
            2:       return 3'b000;
            default: return 3'b101;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive four beats back to back (s_ready expected high in LOAD) and queue results
    task automatic send_frame(input logic [15:0] re4, input logic [15:0] im4);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_re    = re4[i*4 +: 4];
            s_im    = im4[i*4 +: 4];
            check("s_ready_load", {31'd0, s_ready}, 32'd1);
            tick();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, cw_of(i)});
            exp_im_q.push_back(re4[3:0]);
        end
    endtask

    // Wait for result k (3 cycles from ISSUE), optionally stall it for 'hold' cycles
    task automatic receive(input int k, input int hold);
        int n;
        logic [W-1:0] e_re, e_im;
        m_ready = (hold == 0);
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        check("result_latency", n, 3);
        e_re = '0;
        e_im = '0;
        if (exp_q.size() > 0) begin
            e_re = exp_q.pop_front();
            e_im = exp_im_q.pop_front();
        end
        check("m_re", {28'd0, m_re}, {28'd0, e_re});
        check("m_im", {28'd0, m_im}, {28'd0, e_im});
        check("m_idx", {30'd0, m_idx}, k);
        check("bf_c", {29'd0, bf_c1, bf_c2, bf_c3}, {29'd0, cw_of(k)});
        check("s_ready_busy", {31'd0, s_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_stable", {20'd0, m_valid, m_re, m_idx, bf_c1, bf_c2, bf_c3, s_ready},
                  {20'd0, 1'b1, e_re, 2'(k), cw_of(k), 1'b0});
        end
        m_ready = 1'b1;
        tick();
        check("m_valid_drop", {31'd0, m_valid}, 32'd0);
        if (k == 3) begin
            exp_frames++;
            check("s_ready_return", {31'd0, s_ready}, 32'd1);
            check("frame_cnt", {24'd0, frame_cnt}, exp_frames);
        end
    endtask

    task automatic receive_frame();
        for (int k = 0; k < 4; k++) receive(k, 0);
    endtask

    logic [3:0] t4_re [8];
    logic [3:0] t4_im [8];

    initial begin
        int beats, results;
        logic prev_last_hs, hs_in;
        int n;

        // Reset
        RST = 1'b0; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b1; s_re = '0; s_im = '0;
        #12;
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bf_x", {bf_xr, bf_xi}, 32'd0);
        check("rst_outs", {15'd0, m_re, m_im, m_idx, bf_c1, bf_c2, bf_c3}, 32'd0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_LOAD});
        #1 RST = 1'b1;
        tick();

        // T2: basic frame
        send_frame(16'h7531, 16'h8642);
        check("bf_xr_held", {16'd0, bf_xr}, 32'h7531);
        check("bf_xi_held", {16'd0, bf_xi}, 32'h8642);
        check("busy_active", {31'd0, busy}, 32'd1);
        receive_frame();

        // T3: backpressure at k=1
        send_frame(16'h7531, 16'h8642);
        receive(0, 0);
        receive(1, 10);
        receive(2, 0);
        receive(3, 0);

        // T4: s_valid held for two frames
        t4_re = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
        t4_im = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd1};
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back({1'b0, cw_of(i)});
                exp_im_q.push_back(f == 0 ? 4'd1 : 4'd9);
            end
        end
        beats = 0; results = 0; prev_last_hs = 1'b0;
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && (beats < 8 || results < 8); cyc++) begin
            s_valid = (beats < 8);
            s_re    = t4_re[beats % 8];
            s_im    = t4_im[beats % 8];
            if (prev_last_hs) check("t4_s_ready_reassert", {31'd0, s_ready}, 32'd1);
            if (beats >= 4 && beats < 8 && results < 4)
                check("t4_s_ready_low", {31'd0, s_ready}, 32'd0);
            prev_last_hs = 1'b0;
            if (m_valid) begin
                check("t4_m_re", {28'd0, m_re}, {28'd0, exp_q.pop_front()});
                check("t4_m_im", {28'd0, m_im}, {28'd0, exp_im_q.pop_front()});
                check("t4_m_idx", {30'd0, m_idx}, results % 4);
                results++;
                if (results % 4 == 0) prev_last_hs = 1'b1;
            end
            hs_in = s_valid && s_ready;
            tick();
            if (hs_in) beats++;
        end
        s_valid = 1'b0;
        exp_frames += 2;
        check("t4_results", results, 8);
        check("t4_frame_cnt", {24'd0, frame_cnt}, exp_frames);

        // T5: abort in WAIT of k=2
        send_frame(16'h7531, 16'h8642);
        receive(0, 0);
        receive(1, 0);
        tick();
        check("t5_in_wait", {30'd0, dbg_state}, {30'd0, S_WAIT});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_state_load", {30'd0, dbg_state}, {30'd0, S_LOAD});
        check("t5_m_valid", {31'd0, m_valid}, 32'd0);
        check("t5_s_ready", {31'd0, s_ready}, 32'd1);
        check("t5_frame_cnt", {24'd0, frame_cnt}, exp_frames);
        check("t5_bf_xr_kept", {16'd0, bf_xr}, 32'h7531);
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        void'(exp_im_q.pop_front()); void'(exp_im_q.pop_front());
        send_frame(16'h7531, 16'h8642);
        receive_frame();

        // T6: abort with two samples buffered, beat in the abort cycle dropped
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_re = 4'(9 + 2*i); s_im = 4'(10 + 2*i);
            tick();
        end
        check("t6_busy_partial", {31'd0, busy}, 32'd1);
        s_re = 4'd13; s_im = 4'd14; abort = 1'b1;
        tick();
        abort = 1'b0; s_valid = 1'b0;
        check("t6_busy_cleared", {31'd0, busy}, 32'd0);
        check("t6_frame_cnt", {24'd0, frame_cnt}, exp_frames);
        send_frame(16'h7531, 16'h8642);
        check("t6_bf_xr", {16'd0, bf_xr}, 32'h7531);
        receive_frame();

        // T1: async reset mid-cycle while in OUT
        send_frame(16'h7531, 16'h8642);
        m_ready = 1'b0;
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        check("t1_in_out", {30'd0, dbg_state}, {30'd0, S_OUT});
        #2 RST = 1'b0;
        #1;
        check("t1_s_ready", {31'd0, s_ready}, 32'd1);
        check("t1_m_valid", {31'd0, m_valid}, 32'd0);
        check("t1_bf_c", {29'd0, bf_c1, bf_c2, bf_c3}, 32'd0);
        check("t1_bf_xr", {16'd0, bf_xr}, 32'd0);
        check("t1_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        exp_im_q.delete();
        exp_frames = 0;
        @(negedge CLK);
        RST = 1'b1; m_ready = 1'b1;
        tick();
        check("t1_after_release", {30'd0, dbg_state}, {30'd0, S_LOAD});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
